// File: rtl/micro_sequencer_if.sv
// rtl/micro_sequencer_if.sv - MIR, memory-handshake and flag bundle between the control store/datapath and the micro-sequencer
interface micro_sequencer_if #(
    parameter int DATAWIDTH_JUMPADDRESS = 11,
    parameter int DATAWIDTH_CONDITION   = 3,
    parameter int DATAWIDTH_IR          = 32
);
    logic [DATAWIDTH_CONDITION-1:0]   MICRO_SEQUENCER_Condition_InBus;
    logic [DATAWIDTH_JUMPADDRESS-1:0] MICRO_SEQUENCER_JumpAddress_InBus;
    logic                             MICRO_SEQUENCER_RD_In;
    logic                             MICRO_SEQUENCER_WR_In;
    logic                             MICRO_SEQUENCER_MemReady_In;
    logic [DATAWIDTH_IR-1:0]          MICRO_SEQUENCER_IR_InBus;
    logic [3:0]                       MICRO_SEQUENCER_ALUFlags_InBus;
    logic                             MICRO_SEQUENCER_FlagLoad_In;
    logic [DATAWIDTH_JUMPADDRESS-1:0] MICRO_SEQUENCER_CSAddress_OutBus;
    logic [3:0]                       MICRO_SEQUENCER_PSRFlags_OutBus;
    logic                             MICRO_SEQUENCER_Stall_Out;

    // Control store / datapath side.
    modport master (
        output MICRO_SEQUENCER_Condition_InBus,
        output MICRO_SEQUENCER_JumpAddress_InBus,
        output MICRO_SEQUENCER_RD_In,
        output MICRO_SEQUENCER_WR_In,
        output MICRO_SEQUENCER_MemReady_In,
        output MICRO_SEQUENCER_IR_InBus,
        output MICRO_SEQUENCER_ALUFlags_InBus,
        output MICRO_SEQUENCER_FlagLoad_In,
        input  MICRO_SEQUENCER_CSAddress_OutBus,
        input  MICRO_SEQUENCER_PSRFlags_OutBus,
        input  MICRO_SEQUENCER_Stall_Out
    );

    // Sequencer side.
    modport slave (
        input  MICRO_SEQUENCER_Condition_InBus,
        input  MICRO_SEQUENCER_JumpAddress_InBus,
        input  MICRO_SEQUENCER_RD_In,
        input  MICRO_SEQUENCER_WR_In,
        input  MICRO_SEQUENCER_MemReady_In,
        input  MICRO_SEQUENCER_IR_InBus,
        input  MICRO_SEQUENCER_ALUFlags_InBus,
        input  MICRO_SEQUENCER_FlagLoad_In,
        output MICRO_SEQUENCER_CSAddress_OutBus,
        output MICRO_SEQUENCER_PSRFlags_OutBus,
        output MICRO_SEQUENCER_Stall_Out
    );
endinterface

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - Microprogram counter, next-address select, PSR flags and memory stall for the ARC control store
module micro_sequencer #(
    parameter int DATAWIDTH_JUMPADDRESS = 11,
    parameter int DATAWIDTH_CONDITION   = 3,
    parameter int DATAWIDTH_IR          = 32
) (
    input  logic             MICRO_SEQUENCER_CLOCK_50,
    input  logic             MICRO_SEQUENCER_ResetInLow_In,
    micro_sequencer_if.slave bus
);
    localparam logic [DATAWIDTH_JUMPADDRESS-1:0] MPC_ONE = {{(DATAWIDTH_JUMPADDRESS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        COND_NEXT   = 3'b000,
        COND_N      = 3'b001,
        COND_Z      = 3'b010,
        COND_V      = 3'b011,
        COND_C      = 3'b100,
        COND_IR13   = 3'b101,
        COND_JUMP   = 3'b110,
        COND_DECODE = 3'b111
    } cond_e;

    logic [DATAWIDTH_JUMPADDRESS-1:0] mpc_q, mpc_d;
    logic [3:0]                       psr_q, psr_d;

    logic                             stall;
    logic [DATAWIDTH_JUMPADDRESS-1:0] mpc_inc;
    logic [DATAWIDTH_JUMPADDRESS-1:0] decode_addr;
    logic                             take_jump;
    logic                             flag_n, flag_z, flag_v, flag_c;
    cond_e                            cond;

    assign flag_n = psr_q[3];
    assign flag_z = psr_q[2];
    assign flag_v = psr_q[1];
    assign flag_c = psr_q[0];

    assign cond = cond_e'(bus.MICRO_SEQUENCER_Condition_InBus);

    // Outstanding RD/WR freezes the whole block until memory acknowledges.
    assign stall = (bus.MICRO_SEQUENCER_RD_In | bus.MICRO_SEQUENCER_WR_In)
                 & ~bus.MICRO_SEQUENCER_MemReady_In;

    assign mpc_inc = mpc_q + MPC_ONE;

    // op/op3 map straight into a 4-word-aligned slot in the upper half of the store.
    assign decode_addr = {1'b1,
                          bus.MICRO_SEQUENCER_IR_InBus[31:30],
                          bus.MICRO_SEQUENCER_IR_InBus[24:19],
                          2'b00};

    // Branches test the registered PSR, so a CC-setting op cannot branch on its own result.
    always_comb begin
        take_jump = 1'b0;
        case (cond)
            COND_N:    take_jump = flag_n;
            COND_Z:    take_jump = flag_z;
            COND_V:    take_jump = flag_v;
            COND_C:    take_jump = flag_c;
            COND_IR13: take_jump = bus.MICRO_SEQUENCER_IR_InBus[13];
            COND_JUMP: take_jump = 1'b1;
            default:   take_jump = 1'b0;
        endcase
    end

    always_comb begin
        mpc_d = mpc_q;
        psr_d = psr_q;
        if (!stall) begin
            if (cond == COND_DECODE) begin
                mpc_d = decode_addr;
            end else if (take_jump) begin
                mpc_d = bus.MICRO_SEQUENCER_JumpAddress_InBus;
            end else begin
                mpc_d = mpc_inc;
            end
            if (bus.MICRO_SEQUENCER_FlagLoad_In) begin
                psr_d = bus.MICRO_SEQUENCER_ALUFlags_InBus;
            end
        end
    end

    always_ff @(posedge MICRO_SEQUENCER_CLOCK_50 or negedge MICRO_SEQUENCER_ResetInLow_In) begin
        if (!MICRO_SEQUENCER_ResetInLow_In) begin
            mpc_q <= '0;
            psr_q <= 4'b0000;
        end else begin
            mpc_q <= mpc_d;
            psr_q <= psr_d;
        end
    end

    assign bus.MICRO_SEQUENCER_CSAddress_OutBus = mpc_q;
    assign bus.MICRO_SEQUENCER_PSRFlags_OutBus  = psr_q;
    assign bus.MICRO_SEQUENCER_Stall_Out        = stall;

endmodule
